// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: splits the fetched word into ALU controls and operands,
// and presents them as a registered bundle behind a valid/ready handshake.
module rv32i_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        r_type,
  output logic        i_type,
  output logic        b_type,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        op_consShf,
  output logic        sub_sign_extEn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  instr_funct3,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic        w_accept;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;

  logic        w_r_type;
  logic        w_i_type;
  logic        w_b_type;
  logic [2:0]  w_alu_funct3;
  logic [6:0]  w_alu_funct7;
  logic        w_op_consShf;
  logic        w_sub_sign_extEn;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic        w_reg_we;
  logic        w_illegal;

  logic        r_out_valid;
  logic        r_r_type;
  logic        r_i_type;
  logic        r_b_type;
  logic [2:0]  r_alu_funct3;
  logic [6:0]  r_alu_funct7;
  logic        r_op_consShf;
  logic        r_sub_sign_extEn;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_instr_funct3;
  logic [4:0]  r_rd;
  logic        r_reg_we;
  logic        r_illegal;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign in_ready = (~r_out_valid | out_ready) & ~rst;
  assign w_accept = in_valid & in_ready;

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_u = {instr[31:12], 12'h000};

  // Opcode decode into the ALU control/operand bundle.
  always_comb begin
    w_r_type         = 1'b0;
    w_i_type         = 1'b0;
    w_b_type         = 1'b0;
    w_alu_funct3     = 3'b000;
    w_alu_funct7     = 7'b0000000;
    w_op_consShf     = 1'b0;
    w_sub_sign_extEn = 1'b0;
    w_alu_a          = 32'h0000_0000;
    w_alu_b          = 32'h0000_0000;
    w_reg_we         = 1'b0;
    w_illegal        = 1'b0;
    case (instr[6:0])
      OPC_R: begin
        w_r_type     = 1'b1;
        w_alu_funct3 = instr[14:12];
        w_alu_funct7 = instr[31:25];
        w_alu_a      = rs1_data;
        w_alu_b      = rs2_data;
        w_reg_we     = 1'b1;
      end
      OPC_IMM: begin
        w_i_type     = 1'b1;
        w_alu_funct3 = instr[14:12];
        w_alu_funct7 = instr[31:25];
        w_op_consShf = (instr[14:12] == 3'b101);
        w_alu_a      = rs1_data;
        w_alu_b      = w_imm_i;
        w_reg_we     = 1'b1;
      end
      OPC_BRANCH: begin
        // Branches reuse the subtractor; signed compares need the 33rd bit.
        w_b_type         = 1'b1;
        w_alu_funct7     = 7'b0100000;
        w_sub_sign_extEn = (instr[14:12] == 3'b100) | (instr[14:12] == 3'b101);
        w_alu_a          = rs1_data;
        w_alu_b          = rs2_data;
      end
      OPC_LOAD: begin
        w_alu_a  = rs1_data;
        w_alu_b  = w_imm_i;
        w_reg_we = 1'b1;
      end
      OPC_STORE: begin
        w_alu_a = rs1_data;
        w_alu_b = w_imm_s;
      end
      OPC_LUI: begin
        w_alu_b  = w_imm_u;
        w_reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        w_alu_a  = pc;
        w_alu_b  = w_imm_u;
        w_reg_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_alu_a  = pc;
        w_alu_b  = 32'd4;
        w_reg_we = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    if (instr[11:7] == 5'd0) begin
      w_reg_we = 1'b0;
    end else begin
      w_reg_we = w_reg_we;
    end
  end

  // Output register: flush drops everything, acceptance loads, consumption empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_r_type         <= 1'b0;
      r_i_type         <= 1'b0;
      r_b_type         <= 1'b0;
      r_alu_funct3     <= 3'b000;
      r_alu_funct7     <= 7'b0000000;
      r_op_consShf     <= 1'b0;
      r_sub_sign_extEn <= 1'b0;
      r_alu_a          <= 32'h0000_0000;
      r_alu_b          <= 32'h0000_0000;
      r_instr_funct3   <= 3'b000;
      r_rd             <= 5'd0;
      r_reg_we         <= 1'b0;
      r_illegal        <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid      <= 1'b1;
      r_r_type         <= w_r_type;
      r_i_type         <= w_i_type;
      r_b_type         <= w_b_type;
      r_alu_funct3     <= w_alu_funct3;
      r_alu_funct7     <= w_alu_funct7;
      r_op_consShf     <= w_op_consShf;
      r_sub_sign_extEn <= w_sub_sign_extEn;
      r_alu_a          <= w_alu_a;
      r_alu_b          <= w_alu_b;
      r_instr_funct3   <= instr[14:12];
      r_rd             <= instr[11:7];
      r_reg_we         <= w_reg_we;
      r_illegal        <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid      = r_out_valid;
  assign r_type         = r_r_type;
  assign i_type         = r_i_type;
  assign b_type         = r_b_type;
  assign alu_funct3     = r_alu_funct3;
  assign alu_funct7     = r_alu_funct7;
  assign op_consShf     = r_op_consShf;
  assign sub_sign_extEn = r_sub_sign_extEn;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign instr_funct3   = r_instr_funct3;
  assign rd             = r_rd;
  assign reg_we         = r_reg_we;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        r_type, i_type, b_type;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        op_consShf;
  logic        sub_sign_extEn;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  instr_funct3;
  logic [4:0]  rd;
  logic        reg_we;
  logic        illegal;

  typedef struct packed {
    logic        r, i, b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        shf, sx;
    logic [31:0] a, bv;
    logic [2:0]  if3;
    logic [4:0]  rd;
    logic        we, ill;
  } bundle_t;

  logic [31:0] rf [32];
  bundle_t     m_b;
  logic        m_valid;
  logic        chk_en;
  int          checks;
  int          failures;

  assign rs1_data = rf[instr[19:15]];
  assign rs2_data = rf[instr[24:20]];

  always #5 clk = ~clk;

  rv32i_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_type(r_type), .i_type(i_type), .b_type(b_type),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .op_consShf(op_consShf), .sub_sign_extEn(sub_sign_extEn),
    .alu_a(alu_a), .alu_b(alu_b), .instr_funct3(instr_funct3),
    .rd(rd), .reg_we(reg_we), .illegal(illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA encoding rules.
  function automatic bundle_t decode(input logic [31:0] ins, input logic [31:0] pcv,
                                     input logic [31:0] d1, input logic [31:0] d2);
    bundle_t o;
    int      imm_i, imm_s;
    logic [31:0] upper;
    o = '0;
    imm_i = $signed(ins) >>> 20;
    imm_s = ((($signed(ins) >>> 25)) * 32) + int'(ins[11:7]);
    upper = (ins >> 12) * 4096;
    o.if3 = ins[14:12];
    o.rd  = ins[11:7];
    case (ins[6:0])
      7'h33: begin o.r = 1'b1; o.f3 = ins[14:12]; o.f7 = ins[31:25]; o.a = d1; o.bv = d2; o.we = 1'b1; end
      7'h13: begin
        o.i = 1'b1; o.f3 = ins[14:12]; o.f7 = ins[31:25];
        o.shf = (ins[14:12] == 3'd5); o.a = d1; o.bv = imm_i; o.we = 1'b1;
      end
      7'h63: begin
        o.b = 1'b1; o.f7 = 7'd32; o.a = d1; o.bv = d2;
        o.sx = (ins[14:12] == 3'd4) || (ins[14:12] == 3'd5);
      end
      7'h03: begin o.a = d1; o.bv = imm_i; o.we = 1'b1; end
      7'h23: begin o.a = d1; o.bv = imm_s; end
      7'h37: begin o.bv = upper; o.we = 1'b1; end
      7'h17: begin o.a = pcv; o.bv = upper; o.we = 1'b1; end
      7'h6F, 7'h67: begin o.a = pcv; o.bv = 32'd4; o.we = 1'b1; end
      default: o.ill = 1'b1;
    endcase
    if (o.rd == 5'd0) o.we = 1'b0;
    return o;
  endfunction

  // Model of the handshake register, sampled on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_b     = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_b     = decode(instr, pc, rf[instr[19:15]], rf[instr[24:20]]);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready) && !rst});
      chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, instr[19:15]});
      chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, instr[24:20]});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("r_type", {31'd0, r_type}, {31'd0, m_b.r});
      chk("i_type", {31'd0, i_type}, {31'd0, m_b.i});
      chk("b_type", {31'd0, b_type}, {31'd0, m_b.b});
      chk("alu_funct3", {29'd0, alu_funct3}, {29'd0, m_b.f3});
      chk("alu_funct7", {25'd0, alu_funct7}, {25'd0, m_b.f7});
      chk("op_consShf", {31'd0, op_consShf}, {31'd0, m_b.shf});
      chk("sub_sign_extEn", {31'd0, sub_sign_extEn}, {31'd0, m_b.sx});
      chk("alu_a", alu_a, m_b.a);
      chk("alu_b", alu_b, m_b.bv);
      chk("instr_funct3", {29'd0, instr_funct3}, {29'd0, m_b.if3});
      chk("rd", {27'd0, rd}, {27'd0, m_b.rd});
      chk("reg_we", {31'd0, reg_we}, {31'd0, m_b.we});
      chk("illegal", {31'd0, illegal}, {31'd0, m_b.ill});
    end
  end

  // One-instruction transfer; returns at the negedge where the bundle is visible.
  task automatic send(input logic [31:0] ins);
    @(posedge clk); #2;
    in_valid = 1'b1; instr = ins; pc = 32'h0000_1000;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [6:0] ops [10];
  logic [31:0] hold_b;

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0000_0013; pc = 32'h0;
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    rf[1] = 32'd5; rf[2] = 32'd7;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h63; ops[3] = 7'h03; ops[4] = 7'h23;
    ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F; ops[8] = 7'h67; ops[9] = 7'h7F;

    @(posedge clk); #1; chk_en = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #2; rst = 1'b0;

    send(32'h002081B3);
    chk("add_r_type", {31'd0, r_type}, 32'd1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_rd", {27'd0, rd}, 32'd3);
    chk("add_we", {31'd0, reg_we}, 32'd1);
    send(32'h402081B3);
    chk("sub_f7", {25'd0, alu_funct7}, 32'h20);
    send(32'hFFF00293);
    chk("addi_i_type", {31'd0, i_type}, 32'd1);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, rd}, 32'd5);
    send(32'h4030D313);
    chk("srai_shf", {31'd0, op_consShf}, 32'd1);
    chk("srai_f3", {29'd0, alu_funct3}, 32'd5);
    chk("srai_f7", {25'd0, alu_funct7}, 32'h20);
    chk("srai_b", alu_b, 32'h403);
    send(32'h0020C463);
    chk("blt_b_type", {31'd0, b_type}, 32'd1);
    chk("blt_f3", {29'd0, alu_funct3}, 32'd0);
    chk("blt_f7", {25'd0, alu_funct7}, 32'h20);
    chk("blt_sx", {31'd0, sub_sign_extEn}, 32'd1);
    chk("blt_if3", {29'd0, instr_funct3}, 32'd4);
    chk("blt_we", {31'd0, reg_we}, 32'd0);
    send(32'h123453B7);
    chk("lui_a", alu_a, 32'd0);
    chk("lui_b", alu_b, 32'h1234_5000);
    send(32'h0000037F);
    chk("illegal_flag", {31'd0, illegal}, 32'd1);
    chk("illegal_we", {31'd0, reg_we}, 32'd0);
    chk("illegal_b", alu_b, 32'd0);
    send(32'h00500013);
    chk("addi_x0_we", {31'd0, reg_we}, 32'd0);
    chk("addi_x0_b", alu_b, 32'd5);

    // Backpressure: first word loads, then stage stalls for three cycles.
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h06408093;
    @(posedge clk); #2;
    instr = 32'h00A00113;
    hold_b = 32'd100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_b", alu_b, hold_b);
      chk("bp_hold_rd", {27'd0, rd}, 32'd1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_b", alu_b, 32'd10);
    chk("bp_release_rd", {27'd0, rd}, 32'd2);

    // Flush with a simultaneous offer.
    @(posedge clk); #2;
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00300193;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_payload", alu_b, 32'd10);

    // Reset mid-stream.
    send(32'h002081B3);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Randomized traffic.
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      pc        = $urandom & 32'hFFFF_FFFC;
      instr     = {$urandom_range(0, 32'h01FF_FFFF), ops[$urandom_range(0, 9)]};
    end
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
